// File: rtl/wb_regfile_commit.sv
// Write-back stage: result select, load extension, 32x32 GPR file with write-through read ports,
// registered commit trace. Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_regfile_commit #(
    localparam int unsigned DW   = 32,
    localparam int unsigned NREG = 32,
    localparam int unsigned AW   = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_valid,
    input  logic [2:0]    MemtoReg,
    input  logic          RegWrite,
    input  logic [AW-1:0] WReg,
    input  logic [DW-1:0] ALUS,
    input  logic [DW-1:0] dmOut,
    input  logic [DW-1:0] pc8,
    input  logic [DW-1:0] HILO,
    input  logic [DW-1:0] CP0Out,
    input  logic [2:0]    load_ext_op,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    output logic [DW-1:0] rs_data,
    output logic [DW-1:0] rt_data,
    output logic [DW-1:0] wb_data,
    output logic          trc_we,
    output logic [AW-1:0] trc_wreg,
    output logic [DW-1:0] trc_wdata,
    output logic [DW-1:0] trc_pc,
    output logic [DW-1:0] retire_cnt
);

    localparam logic [2:0] SEL_ALU  = 3'd0;
    localparam logic [2:0] SEL_MEM  = 3'd1;
    localparam logic [2:0] SEL_LINK = 3'd2;
    localparam logic [2:0] SEL_HILO = 3'd3;
    localparam logic [2:0] SEL_CP0  = 3'd4;

    localparam logic [2:0] EXT_LBU = 3'd1;
    localparam logic [2:0] EXT_LB  = 3'd2;
    localparam logic [2:0] EXT_LHU = 3'd3;
    localparam logic [2:0] EXT_LH  = 3'd4;

    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [DW-1:0] ld_data;
    logic          commit;

    logic [DW-1:0] gpr_q [NREG];
    logic [DW-1:0] gpr_d [NREG];

    logic          trc_we_q,    trc_we_d;
    logic [AW-1:0] trc_wreg_q,  trc_wreg_d;
    logic [DW-1:0] trc_wdata_q, trc_wdata_d;
    logic [DW-1:0] trc_pc_q,    trc_pc_d;

    // Little-endian lane pick and load extension; offset is ignored for word loads.
    always_comb begin
        ld_byte = dmOut[7:0];
        case (ALUS[1:0])
            2'd0:    ld_byte = dmOut[7:0];
            2'd1:    ld_byte = dmOut[15:8];
            2'd2:    ld_byte = dmOut[23:16];
            default: ld_byte = dmOut[31:24];
        endcase
        ld_half = ALUS[1] ? dmOut[31:16] : dmOut[15:0];

        ld_data = dmOut;
        case (load_ext_op)
            EXT_LBU: ld_data = {24'd0, ld_byte};
            EXT_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            EXT_LHU: ld_data = {16'd0, ld_half};
            EXT_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
            default: ld_data = dmOut;
        endcase
    end

    always_comb begin
        wb_data = '0;
        case (MemtoReg)
            SEL_ALU:  wb_data = ALUS;
            SEL_MEM:  wb_data = ld_data;
            SEL_LINK: wb_data = pc8;
            SEL_HILO: wb_data = HILO;
            SEL_CP0:  wb_data = CP0Out;
            default:  wb_data = '0;
        endcase
    end

    // Bubbles never write, and $0 is never a real destination.
    assign commit = wb_valid & RegWrite & (WReg != AW'(0));

    // Same-cycle commit is visible at the read ports before it lands in the array.
    always_comb begin
        if (rs_addr == AW'(0)) begin
            rs_data = '0;
        end else if (commit && (rs_addr == WReg)) begin
            rs_data = wb_data;
        end else begin
            rs_data = gpr_q[rs_addr];
        end

        if (rt_addr == AW'(0)) begin
            rt_data = '0;
        end else if (commit && (rt_addr == WReg)) begin
            rt_data = wb_data;
        end else begin
            rt_data = gpr_q[rt_addr];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            gpr_d[i] = gpr_q[i];
        end
        if (commit) begin
            gpr_d[WReg] = wb_data;
        end
        gpr_d[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                gpr_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                gpr_q[i] <= gpr_d[i];
            end
        end
    end

    // Trace holds the last commit's details until the next commit.
    always_comb begin
        trc_we_d    = commit;
        trc_wreg_d  = trc_wreg_q;
        trc_wdata_d = trc_wdata_q;
        trc_pc_d    = trc_pc_q;
        if (commit) begin
            trc_wreg_d  = WReg;
            trc_wdata_d = wb_data;
            trc_pc_d    = DW'(pc8 - DW'(8));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trc_we_q    <= 1'b0;
            trc_wreg_q  <= '0;
            trc_wdata_q <= '0;
            trc_pc_q    <= '0;
        end else begin
            trc_we_q    <= trc_we_d;
            trc_wreg_q  <= trc_wreg_d;
            trc_wdata_q <= trc_wdata_d;
            trc_pc_q    <= trc_pc_d;
        end
    end

    assign trc_we    = trc_we_q;
    assign trc_wreg  = trc_wreg_q;
    assign trc_wdata = trc_wdata_q;
    assign trc_pc    = trc_pc_q;

`ifdef WB_RETIRE_CNT_EN
    logic [DW-1:0] retire_q, retire_d;

    // Every valid slot retires, writing or not; wraps naturally.
    always_comb begin
        retire_d = retire_q;
        if (wb_valid) begin
            retire_d = DW'(retire_q + DW'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_q <= '0;
        end else begin
            retire_q <= retire_d;
        end
    end

    assign retire_cnt = retire_q;
`else
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_regfile_commit.sv
// Scoreboard bench for wb_regfile_commit: trace expectations queued at drive time, popped after each edge.
module tb_wb_regfile_commit;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic [2:0]  MemtoReg;
    logic        RegWrite;
    logic [4:0]  WReg;
    logic [31:0] ALUS, dmOut, pc8, HILO, CP0Out;
    logic [2:0]  load_ext_op;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data, wb_data;
    logic        trc_we;
    logic [4:0]  trc_wreg;
    logic [31:0] trc_wdata, trc_pc, retire_cnt;

    wb_regfile_commit dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .WReg(WReg), .ALUS(ALUS), .dmOut(dmOut), .pc8(pc8), .HILO(HILO), .CP0Out(CP0Out),
        .load_ext_op(load_ext_op), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data), .wb_data(wb_data),
        .trc_we(trc_we), .trc_wreg(trc_wreg), .trc_wdata(trc_wdata), .trc_pc(trc_pc),
        .retire_cnt(retire_cnt)
    );

    typedef struct packed {
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [31:0] pc;
    } trc_t;

    trc_t        sb[$];
    logic [31:0] mregs [32];
    trc_t        mtrc;
    logic [31:0] mcnt;
    int          n_vec;
    int          n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_wb(input logic [2:0] sel, input logic [2:0] ext,
                                           input logic [31:0] alus, input logic [31:0] dm,
                                           input logic [31:0] link, input logic [31:0] hilo,
                                           input logic [31:0] cp0);
        logic [31:0] sh;
        logic [31:0] ld;
        sh = dm >> (8 * alus[1:0]);
        case (ext)
            3'd1: ld = sh & 32'h0000_00FF;
            3'd2: ld = sh[7] ? (sh | 32'hFFFF_FF00) : (sh & 32'h0000_00FF);
            3'd3: ld = alus[1] ? (dm >> 16) : (dm & 32'h0000_FFFF);
            3'd4: begin
                ld = alus[1] ? (dm >> 16) : (dm & 32'h0000_FFFF);
                if (ld[15]) ld = ld | 32'hFFFF_0000;
            end
            default: ld = dm;
        endcase
        case (sel)
            3'd0: return alus;
            3'd1: return ld;
            3'd2: return link;
            3'd3: return hilo;
            3'd4: return cp0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] exp_cnt();
`ifdef WB_RETIRE_CNT_EN
        return mcnt;
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        mtrc = '0;
        mcnt = 32'd0;
        sb.delete();
    endtask

    // Drive one WB slot, check combinational outputs, queue the trace, then check after the edge.
    task automatic apply(input logic v, input logic [2:0] sel, input logic rw, input logic [4:0] wr,
                         input logic [31:0] alus, input logic [31:0] dm, input logic [31:0] link,
                         input logic [31:0] hilo, input logic [31:0] cp0, input logic [2:0] ext,
                         input logic [4:0] ra, input logic [4:0] rb);
        logic [31:0] ew, ea, eb;
        logic        cm;
        trc_t        got;
        trc_t        exp;
        wb_valid = v; MemtoReg = sel; RegWrite = rw; WReg = wr; ALUS = alus; dmOut = dm;
        pc8 = link; HILO = hilo; CP0Out = cp0; load_ext_op = ext; rs_addr = ra; rt_addr = rb;
        #1;
        ew = ref_wb(sel, ext, alus, dm, link, hilo, cp0);
        cm = v && rw && (wr != 5'd0);
        ea = (ra == 5'd0) ? 32'd0 : ((cm && ra == wr) ? ew : mregs[ra]);
        eb = (rb == 5'd0) ? 32'd0 : ((cm && rb == wr) ? ew : mregs[rb]);
        chk("wb_data", wb_data, ew);
        chk("rs_data", rs_data, ea);
        chk("rt_data", rt_data, eb);
        if (cm) begin
            mregs[wr] = ew;
            mtrc = '{we: 1'b1, wreg: wr, wdata: ew, pc: link - 32'd8};
        end else begin
            mtrc.we = 1'b0;
        end
        if (v) mcnt = mcnt + 32'd1;
        sb.push_back(mtrc);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            exp = sb.pop_front();
            got = '{we: trc_we, wreg: trc_wreg, wdata: trc_wdata, pc: trc_pc};
            chk("trc_we", 32'(got.we), 32'(exp.we));
            chk("trc_wreg", 32'(got.wreg), 32'(exp.wreg));
            chk("trc_wdata", got.wdata, exp.wdata);
            chk("trc_pc", got.pc, exp.pc);
        end
        chk("retire_cnt", retire_cnt, exp_cnt());
    endtask

    // Combinational read of one register with an absolute expected value, no clock edge.
    task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] e);
        wb_valid = 1'b0; RegWrite = 1'b0; rs_addr = a; rt_addr = a;
        #1;
        chk(tag, rs_data, e);
        chk(tag, rt_data, e);
    endtask

    task automatic bubble(input logic [4:0] ra, input logic [4:0] rb);
        apply(1'b0, 3'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd8, 32'd0, 32'd0, 3'd0, ra, rb);
    endtask

    logic [31:0] cnt0;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        wb_valid = 1'b0; MemtoReg = 3'd0; RegWrite = 1'b0; WReg = 5'd0;
        ALUS = 32'd0; dmOut = 32'd0; pc8 = 32'd0; HILO = 32'd0; CP0Out = 32'd0;
        load_ext_op = 3'd0; rs_addr = 5'd0; rt_addr = 5'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_trc_we", 32'(trc_we), 32'd0);
        chk("rst_trc_pc", trc_pc, 32'd0);
        chk("rst_retire", retire_cnt, 32'd0);
        rst = 1'b0;

        // Load extension cases
        apply(1'b1, 3'd1, 1'b1, 5'd8, 32'h1001, 32'h0000_80FF, 32'h108, 0, 0, 3'd2, 5'd8, 5'd0);
        peek("t2_lb", 5'd8, 32'hFFFF_FF80);
        apply(1'b1, 3'd1, 1'b1, 5'd8, 32'h1002, 32'h1234_5678, 32'h10C, 0, 0, 3'd3, 5'd8, 5'd8);
        peek("t2_lhu", 5'd8, 32'h0000_1234);

        // Write to $0 is dropped
        apply(1'b1, 3'd0, 1'b1, 5'd0, 32'hDEAD_BEEF, 0, 32'h110, 0, 0, 3'd0, 5'd0, 5'd0);
        chk("t3_trc_we", 32'(trc_we), 32'd0);
        peek("t3_r0", 5'd0, 32'd0);

        // Same-cycle bypass on both ports, link value and trace pc
        wb_valid = 1'b1; MemtoReg = 3'd2; RegWrite = 1'b1; WReg = 5'd5; pc8 = 32'h3008;
        rs_addr = 5'd5; rt_addr = 5'd5;
        #1;
        chk("t4_rs_bypass", rs_data, 32'h3008);
        chk("t4_rt_bypass", rt_data, 32'h3008);
        apply(1'b1, 3'd2, 1'b1, 5'd5, 32'h0, 0, 32'h3008, 0, 0, 3'd0, 5'd5, 5'd5);
        chk("t4_trc_pc", trc_pc, 32'h3000);
        peek("t4_array", 5'd5, 32'h3008);

        // Bubble with RegWrite never writes
        apply(1'b1, 3'd0, 1'b1, 5'd9, 32'h0000_0099, 0, 32'h200, 0, 0, 3'd0, 5'd9, 5'd0);
        apply(1'b0, 3'd0, 1'b1, 5'd9, 32'h5555_AAAA, 0, 32'h204, 0, 0, 3'd0, 5'd9, 5'd9);
        peek("t5_gpr9", 5'd9, 32'h0000_0099);

        // CP0 then HILO to the same register
        apply(1'b1, 3'd4, 1'b1, 5'd31, 0, 0, 32'h308, 0, 32'h0000_1234, 3'd0, 5'd31, 5'd1);
        apply(1'b1, 3'd3, 1'b1, 5'd31, 0, 0, 32'h30C, 32'hCAFE_0000, 0, 3'd0, 5'd31, 5'd31);
        peek("t6_gpr31", 5'd31, 32'hCAFE_0000);

        // Random traffic covering all selects, extensions, offsets and destinations
        for (int i = 0; i < 300; i++) begin
            apply(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 1'($urandom),
                  5'($urandom), $urandom, $urandom, $urandom, $urandom, $urandom,
                  3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom));
        end

        // Reset pulse mid-cycle, with a would-be commit held across the edge
        wb_valid = 1'b1; RegWrite = 1'b1; MemtoReg = 3'd0; WReg = 5'd3; ALUS = 32'h7777_7777;
        #2;
        rst = 1'b1;
        #1;
        chk("t1_trc_we", 32'(trc_we), 32'd0);
        chk("t1_trc_wreg", 32'(trc_wreg), 32'd0);
        chk("t1_trc_wdata", trc_wdata, 32'd0);
        chk("t1_trc_pc", trc_pc, 32'd0);
        chk("t1_retire", retire_cnt, 32'd0);
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        RegWrite = 1'b0;
        for (int a = 1; a < 32; a++) begin
            rs_addr = 5'(a);
            rt_addr = 5'(32 - a);
            #1;
            chk("t1_rs_zero", rs_data, 32'd0);
            chk("t1_rt_zero", rt_data, 32'd0);
        end
        rst = 1'b0;
        model_reset();

        // Retire count: 10 valid + 3 bubbles
        cnt0 = mcnt;
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, 3'd0, 1'(i % 2), 5'(i + 10), 32'(i), 0, 32'h400, 0, 0, 3'd0, 5'(i + 10), 5'd3);
        end
        for (int i = 0; i < 3; i++) bubble(5'd3, 5'd12);
        `ifdef WB_RETIRE_CNT_EN
        chk("t5_retire10", retire_cnt, 32'd10);
        `else
        chk("t5_retire_tied", retire_cnt, 32'd0);
        `endif
        peek("t1_no_commit_r3", 5'd3, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
